// File: rtl/sdram_responder_if.sv
// SDR SDRAM command/data bus between a controller (master) and the
// sdram_responder device model (slave).
//   cke, cs_n, ras, cas, we : clock enable and command strobes (active-low style)
//   address, bank           : row / column / mode word and bank select
//   data_in, data_mask      : write data and DQM byte masks (high = masked)
//   data_out, data_oe       : read data and its valid / drive enable
//   ready, mode_reg         : init complete flag and last MRS value
//   error, error_code       : sticky protocol error and first error code
interface sdram_responder_if;
  logic        cke;
  logic        cs_n;
  logic        ras;
  logic        cas;
  logic        we;
  logic [11:0] address;
  logic [1:0]  bank;
  logic [15:0] data_in;
  logic [1:0]  data_mask;
  logic [15:0] data_out;
  logic        data_oe;
  logic        ready;
  logic [11:0] mode_reg;
  logic        error;
  logic [3:0]  error_code;

  modport master (
    output cke, cs_n, ras, cas, we, address, bank, data_in, data_mask,
    input  data_out, data_oe, ready, mode_reg, error, error_code
  );

  modport slave (
    input  cke, cs_n, ras, cas, we, address, bank, data_in, data_mask,
    output data_out, data_oe, ready, mode_reg, error, error_code
  );
endinterface

// File: rtl/sdram_responder.sv
// SDR SDRAM device emulator. Decodes the controller's command bus, tracks the
// power-up sequence, mode register, per-bank open rows, read/write bursts with
// CAS latency, and the refresh deadline, backed by a 16-bit word array.
// Ports:
//   clk : SDRAM clock, all logic on posedge
//   rst : synchronous, active-high reset
//   bus : sdram_responder_if.slave (command inputs, DQ, status outputs)
module sdram_responder #(
  parameter int ROW_BITS      = 4,
  parameter int COL_BITS      = 8,
  parameter int REFRESH_LIMIT = 1560,
  parameter int INIT_AR_COUNT = 2
) (
  input logic              clk,
  input logic              rst,
  sdram_responder_if.slave bus
);
  localparam int WORD_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int CNT_BITS  = $clog2(REFRESH_LIMIT + 1);
  localparam int AR_BITS   = $clog2(INIT_AR_COUNT + 2);

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000, CMD_AR  = 3'b001, CMD_PRE   = 3'b010, CMD_ACT = 3'b011,
    CMD_WRITE = 3'b100, CMD_READ = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
  } cmd_t;

  typedef enum logic [1:0] {WAIT_PRE, WAIT_AR, WAIT_MRS, READY} init_state_t;

  typedef enum logic [3:0] {
    ERR_NONE = 4'd0, ERR_INIT = 4'd1, ERR_MODE = 4'd2, ERR_MRS_OPEN = 4'd3,
    ERR_ACT_OPEN = 4'd4, ERR_BANK_CLOSED = 4'd5, ERR_CONTENTION = 4'd6,
    ERR_AR_OPEN = 4'd7, ERR_REFRESH = 4'd8
  } err_t;

  init_state_t         state, state_next;
  logic                init_err;
  logic [AR_BITS-1:0]  ar_count;
  logic [11:0]         mode_q;
  logic [3:0]          open_q;
  logic [ROW_BITS-1:0] row_q [4];
  logic                burst_active, burst_write, burst_ap;
  logic [1:0]          burst_bank;
  logic [ROW_BITS-1:0] burst_row;
  logic [COL_BITS-1:0] burst_col;
  logic [3:0]          burst_left;
  logic                ap_pending;
  logic [1:0]          ap_bank;
  logic [2:0]          pipe_valid;
  logic [15:0]         pipe_data [3];
  logic [CNT_BITS-1:0] refresh_count;
  logic [15:0]         data_out_q;
  logic                data_oe_q, error_q;
  err_t                error_code_q, err;
  logic [15:0]         mem [2**WORD_BITS];

  cmd_t cmd;
  logic is_ready, any_open, bank_open, mode_bad, cl3, new_rw, cut, flush;
  logic read_pending, refresh_hit, out_valid;
  logic [15:0] out_data;
  logic [3:0]  burst_len;
  logic [COL_BITS-1:0] col_mask;
  logic                beat_valid, beat_write, beat_ap, beat_last;
  logic [1:0]          beat_bank;
  logic [ROW_BITS-1:0] beat_row;
  logic [COL_BITS-1:0] beat_col, beat_col_next;
  logic [3:0]          beat_len;
  logic [WORD_BITS-1:0] word;
  logic unused_addr;

  assign cmd       = bus.cs_n ? CMD_NOP : cmd_t'({bus.ras, bus.cas, bus.we});
  assign is_ready  = (state == READY);
  assign any_open  = |open_q;
  assign bank_open = open_q[bus.bank];
  assign mode_bad  = (bus.address[2:0] > 3'd3) ||
                     ((bus.address[6:4] != 3'd2) && (bus.address[6:4] != 3'd3));
  assign unused_addr = ^bus.address;

  // Active mode: an out-of-range CL falls back to 3, an out-of-range BL to 1.
  assign cl3 = (mode_q[6:4] != 3'd2);
  always_comb begin
    case (mode_q[2:0])
      3'd1:    burst_len = 4'd2;
      3'd2:    burst_len = 4'd4;
      3'd3:    burst_len = 4'd8;
      default: burst_len = 4'd1;
    endcase
  end
  assign col_mask = COL_BITS'(burst_len - 4'd1);

  // Init sequence, next-state half.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (which would infer a latch).
    state_next = state;
    init_err   = 1'b0;
    if (cmd != CMD_NOP) begin
      case (state)
        WAIT_PRE:
          if (cmd == CMD_PRE && bus.address[10])
            state_next = (INIT_AR_COUNT == 0) ? WAIT_MRS : WAIT_AR;
          else init_err = 1'b1;
        WAIT_AR:
          if (cmd == CMD_AR) begin
            if (ar_count == AR_BITS'(INIT_AR_COUNT - 1)) state_next = WAIT_MRS;
          end else init_err = 1'b1;
        WAIT_MRS:
          if (cmd == CMD_MRS) state_next = READY;
          else init_err = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state is always assigned with <=, so every register samples pre-edge values regardless of statement order.
    if (rst)          state <= WAIT_PRE;
    else if (bus.cke) state <= state_next;
  end

  // Read data in flight: only the first CL stages matter for the output.
  assign read_pending = pipe_valid[0] | pipe_valid[1] | (cl3 & pipe_valid[2]);
  assign out_valid    = cl3 ? pipe_valid[2] : pipe_valid[1];
  assign out_data     = cl3 ? pipe_data[2]  : pipe_data[1];

  // Burst beat for this cycle: a legal new READ/WRITE starts one, otherwise
  // the running burst continues unless cut by BST or PRE to its bank.
  assign new_rw = is_ready && (cmd == CMD_READ || cmd == CMD_WRITE) && bank_open;
  assign cut    = new_rw || (is_ready && (cmd == CMD_BST ||
                  (cmd == CMD_PRE && (bus.address[10] || bus.bank == burst_bank))));
  assign flush  = new_rw && (cmd == CMD_WRITE) && read_pending;

  always_comb begin
    beat_valid = 1'b0;
    beat_write = burst_write;
    beat_bank  = burst_bank;
    beat_row   = burst_row;
    beat_col   = burst_col;
    beat_len   = burst_left;
    beat_ap    = burst_ap;
    if (new_rw) begin
      beat_valid = 1'b1;
      beat_write = (cmd == CMD_WRITE);
      beat_bank  = bus.bank;
      beat_row   = row_q[bus.bank];
      beat_col   = bus.address[COL_BITS-1:0];
      beat_len   = (cmd == CMD_WRITE && mode_q[9]) ? 4'd1 : burst_len;
      beat_ap    = bus.address[10];
    end else if (burst_active && !cut) begin
      beat_valid = 1'b1;
    end
  end

  assign beat_last     = (beat_len == 4'd1);
  // Column advances within the BL-aligned block: low bits wrap, high bits stay.
  assign beat_col_next = (beat_col & ~col_mask) | ((beat_col + COL_BITS'(1)) & col_mask);
  assign word          = {beat_bank, beat_row, beat_col};

  assign refresh_hit = is_ready && (cmd != CMD_AR) &&
                       (refresh_count == CNT_BITS'(REFRESH_LIMIT - 1));

  always_comb begin
    err = ERR_NONE;
    if (init_err) err = ERR_INIT;
    else if (state == WAIT_MRS && cmd == CMD_MRS && mode_bad) err = ERR_MODE;
    else if (is_ready) begin
      case (cmd)
        CMD_ACT:   if (bank_open) err = ERR_ACT_OPEN;
        CMD_READ:  if (!bank_open) err = ERR_BANK_CLOSED;
        CMD_WRITE: if (!bank_open) err = ERR_BANK_CLOSED;
                   else if (read_pending) err = ERR_CONTENTION;
        CMD_MRS:   if (any_open) err = ERR_MRS_OPEN;
                   else if (mode_bad) err = ERR_MODE;
        CMD_AR:    if (any_open) err = ERR_AR_OPEN;
        default: ;
      endcase
      if (err == ERR_NONE && refresh_hit) err = ERR_REFRESH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_count      <= '0;
      mode_q        <= '0;
      open_q        <= '0;
      burst_active  <= 1'b0;
      burst_write   <= 1'b0;
      burst_bank    <= '0;
      burst_row     <= '0;
      burst_col     <= '0;
      burst_left    <= '0;
      burst_ap      <= 1'b0;
      ap_pending    <= 1'b0;
      ap_bank       <= '0;
      pipe_valid    <= '0;
      refresh_count <= '0;
      data_out_q    <= '0;
      data_oe_q     <= 1'b0;
      error_q       <= 1'b0;
      error_code_q  <= ERR_NONE;
    end else if (bus.cke) begin
      if (state == WAIT_AR && cmd == CMD_AR) ar_count <= ar_count + AR_BITS'(1);
      if (cmd == CMD_MRS && (state == WAIT_MRS || (is_ready && !any_open)))
        mode_q <= bus.address;

      // Auto-precharge closes first; this cycle's command acts on the old view.
      if (ap_pending) open_q[ap_bank] <= 1'b0;
      if (is_ready && cmd == CMD_ACT && !bank_open) begin
        open_q[bus.bank] <= 1'b1;
        row_q[bus.bank]  <= bus.address[ROW_BITS-1:0];
      end
      if (is_ready && cmd == CMD_PRE) begin
        if (bus.address[10]) open_q <= '0;
        else                 open_q[bus.bank] <= 1'b0;
      end
      ap_pending <= beat_valid && beat_last && beat_ap;
      if (beat_valid) ap_bank <= beat_bank;

      burst_active <= beat_valid && !beat_last;
      if (beat_valid) begin
        burst_write <= beat_write;
        burst_bank  <= beat_bank;
        burst_row   <= beat_row;
        burst_col   <= beat_col_next;
        burst_left  <= beat_len - 4'd1;
        burst_ap    <= beat_ap;
      end

      pipe_valid <= flush ? 3'b000 : {pipe_valid[1:0], beat_valid && !beat_write};
      data_oe_q  <= out_valid && !flush;
      if (out_valid && !flush) data_out_q <= out_data;

      if (is_ready) begin
        if (cmd == CMD_AR) refresh_count <= '0;
        else if (refresh_count != CNT_BITS'(REFRESH_LIMIT))
          refresh_count <= refresh_count + CNT_BITS'(1);
      end

      if (!error_q && err != ERR_NONE) begin
        error_q      <= 1'b1;
        error_code_q <= err;
      end
    end
  end

  // Storage and read-data pipeline payload.
  always_ff @(posedge clk) begin
    // NOTE: the array and pipeline payload have no reset; contents survive rst and only valid bits qualify the data.
    if (!rst && bus.cke) begin
      if (beat_valid && beat_write) begin
        if (!bus.data_mask[0]) mem[word][7:0]  <= bus.data_in[7:0];
        if (!bus.data_mask[1]) mem[word][15:8] <= bus.data_in[15:8];
      end
      pipe_data[0] <= mem[word];
      pipe_data[1] <= pipe_data[0];
      pipe_data[2] <= pipe_data[1];
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_oe    = data_oe_q;
  assign bus.ready      = is_ready;
  assign bus.mode_reg   = mode_q;
  assign bus.error      = error_q;
  assign bus.error_code = error_code_q;
endmodule
